wb_copy_sequencer: RTL and testbench

//  Word-copy engine sitting directly upstream of the Wishbone master interface.
//  It accepts a copy job (source, destination, length), issues one single read
//  and then one single write per word via the master's start/address/write

---
 rtl/wb_copy_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_wb_copy_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_copy_sequencer.sv
// Word-copy engine feeding a Wishbone master request port: one read then one
// write per word, a single outstanding transfer, with busy/done/error/progress status.
module wb_copy_sequencer #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int lw = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cfg_start,
  input  logic [aw-1:0] cfg_src,
  input  logic [aw-1:0] cfg_dst,
  input  logic [lw-1:0] cfg_len,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [lw-1:0] words_done,
  output logic          start,
  output logic [aw-1:0] address,
  output logic [3:0]    selection,
  output logic          write,
  output logic [dw-1:0] data_wr,
  input  logic [dw-1:0] data_rd,
  input  logic          xfer_done,
  input  logic          xfer_err
);

  localparam logic [aw-1:0] stride = aw'(dw / 8);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [aw-1:0] src_r, src_s;
  logic [aw-1:0] dst_r, dst_s;
  logic [lw-1:0] rem_r, rem_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          error_r, error_s;
  logic [lw-1:0] words_r, words_s;
  logic          start_r, start_s;
  logic [aw-1:0] addr_r, addr_s;
  logic          write_r, write_s;
  logic [dw-1:0] data_r, data_s;

  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign words_done = words_r;
  assign start      = start_r;
  assign address    = addr_r;
  assign selection  = 4'hF;
  assign write      = write_r;
  assign data_wr    = data_r;

  // Next-state and next-register values; pulses default low every cycle.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    rem_s   = rem_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    error_s = error_r;
    words_s = words_r;
    start_s = 1'b0;
    addr_s  = addr_r;
    write_s = write_r;
    data_s  = data_r;
    case (state_r)
      IDLE: begin
        if (cfg_start) begin
          src_s   = cfg_src;
          dst_s   = cfg_dst;
          rem_s   = cfg_len;
          busy_s  = 1'b1;
          error_s = 1'b0;
          words_s = {lw{1'b0}};
          if (cfg_len == {lw{1'b0}}) begin
            state_s = FIN;
          end else begin
            state_s = RD_REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_REQ: begin
        start_s = 1'b1;
        write_s = 1'b0;
        addr_s  = src_r;
        state_s = RD_WAIT;
      end
      RD_WAIT: begin
        // An error response takes priority over a simultaneous ack.
        if (xfer_err) begin
          error_s = 1'b1;
          state_s = FIN;
        end else if (xfer_done) begin
          data_s  = data_rd;
          state_s = WR_REQ;
        end else begin
          state_s = RD_WAIT;
        end
      end
      WR_REQ: begin
        start_s = 1'b1;
        write_s = 1'b1;
        addr_s  = dst_r;
        state_s = WR_WAIT;
      end
      WR_WAIT: begin
        if (xfer_err) begin
          error_s = 1'b1;
          state_s = FIN;
        end else if (xfer_done) begin
          words_s = words_r + lw'(1);
          src_s   = src_r + stride;
          dst_s   = dst_r + stride;
          rem_s   = rem_r - lw'(1);
          if (rem_r == lw'(1)) begin
            state_s = FIN;
          end else begin
            state_s = RD_REQ;
          end
        end else begin
          state_s = WR_WAIT;
        end
      end
      FIN: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job registers and registered outputs; reset abandons any in-flight transfer.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      src_r   <= {aw{1'b0}};
      dst_r   <= {aw{1'b0}};
      rem_r   <= {lw{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      words_r <= {lw{1'b0}};
      start_r <= 1'b0;
      addr_r  <= {aw{1'b0}};
      write_r <= 1'b0;
      data_r  <= {dw{1'b0}};
    end else begin
      src_r   <= src_s;
      dst_r   <= dst_s;
      rem_r   <= rem_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
      words_r <= words_s;
      start_r <= start_s;
      addr_r  <= addr_s;
      write_r <= write_s;
      data_r  <= data_s;
    end
  end

endmodule

// File: tb/tb_wb_copy_sequencer.sv
// Bench for wb_copy_sequencer: behavioural slave with memory, table vectors,
// hand-written corner sequences and randomized jobs against a transfer-list model.
module tb_wb_copy_sequencer;

  logic        wb_clk, wb_rst, cfg_start;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        busy, done, error;
  logic [15:0] words_done;
  logic        start;
  logic [31:0] address;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr, data_rd;
  logic        xfer_done, xfer_err;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hold_ok;
  } xfer_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          lat;
    int          err_idx;
    logic        both;
    int          exp_words;
    logic        exp_err;
    int          exp_xfers;
    string       name;
  } vec_t;

  xfer_t log_q[$];
  vec_t  vecs[9];
  int    checks = 0;
  int    errors = 0;
  int    rst_epoch = 0;
  int    done_total = 0;
  int    job_id = 0;
  int    log_base = 0;
  int    done_base = 0;
  int    lat_cfg = 1;
  int    err_cfg = -1;
  logic  both_cfg = 1'b0;

  wb_copy_sequencer dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cfg_start(cfg_start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .start(start), .address(address), .selection(selection), .write(write),
    .data_wr(data_wr), .data_rd(data_rd), .xfer_done(xfer_done), .xfer_err(xfer_err)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  always @(posedge wb_rst) rst_epoch++;

  always @(posedge wb_clk) begin
    #1;
    if (done === 1'b1) done_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave memory contents as seen by the copy engine.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int model_xfers(input int len, input int err);
    return (err >= 0 && err < 2 * len) ? err + 1 : 2 * len;
  endfunction

  function automatic int model_words(input int len, input int err);
    return (err >= 0 && err < 2 * len) ? err / 2 : len;
  endfunction

  // Slave: logs each request, acks (or errors) after a latency, abandons on reset.
  initial begin : slave
    int   ep, l, idx, last_job;
    logic aborted;
    xfer_t t;
    idx = 0; last_job = -1;
    xfer_done = 1'b0; xfer_err = 1'b0; data_rd = 32'h0;
    forever begin
      @(negedge wb_clk);
      xfer_done = 1'b0;
      xfer_err  = 1'b0;
      if (wb_rst === 1'b0 && start === 1'b1) begin
        if (job_id != last_job) begin
          idx = 0;
          last_job = job_id;
        end
        ep = rst_epoch;
        t.wr = write; t.addr = address;
        t.data = write ? data_wr : 32'h0;
        t.hold_ok = 1'b1;
        log_q.push_back(t);
        l = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
        aborted = 1'b0;
        for (int k = 0; k < l; k++) begin
          @(negedge wb_clk);
          if (wb_rst !== 1'b0 || ep != rst_epoch) aborted = 1'b1;
          if (!aborted && (address !== t.addr || write !== t.wr))
            log_q[log_q.size() - 1].hold_ok = 1'b0;
        end
        if (!aborted) begin
          data_rd = t.wr ? 32'hDEAD_BEEF : mem_word(t.addr);
          if (idx == err_cfg) begin
            xfer_err  = 1'b1;
            xfer_done = both_cfg;
          end else begin
            xfer_done = 1'b1;
          end
          idx++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int len, input string name);
    job_id++;
    log_base  = log_q.size();
    done_base = done_total;
    cfg_src = s; cfg_dst = d; cfg_len = 16'(len); cfg_start = 1'b1;
    @(negedge wb_clk);
    cfg_start = 1'b0;
    chk({name, ":busy_on"}, 64'(busy), 64'(1));
    chk({name, ":error_clr"}, 64'(error), 64'(0));
    chk({name, ":words_clr"}, 64'(words_done), 64'(0));
  endtask

  task automatic finish_check(input logic [31:0] s, input logic [31:0] d, input int len,
                              input int exp_words, input logic exp_err, input int exp_xfers,
                              input string name);
    int    n, got;
    xfer_t e;
    n = 0;
    while (done !== 1'b1 && n < 20 * len + 40) begin
      @(negedge wb_clk);
      n++;
    end
    chk({name, ":done_seen"}, 64'(done), 64'(1));
    chk({name, ":busy_off"}, 64'(busy), 64'(0));
    chk({name, ":words_done"}, 64'(words_done), 64'(exp_words));
    chk({name, ":error"}, 64'(error), 64'(exp_err));
    repeat (4) @(negedge wb_clk);
    got = log_q.size() - log_base;
    chk({name, ":xfer_count"}, 64'(got), 64'(exp_xfers));
    for (int j = 0; j < exp_xfers && j < got; j++) begin
      e.wr   = (j % 2) == 1;
      e.addr = (e.wr ? d : s) + 32'(4 * (j / 2));
      e.data = mem_word(s + 32'(4 * (j / 2)));
      chk($sformatf("%s:x%0d_write", name, j), 64'(log_q[log_base + j].wr), 64'(e.wr));
      chk($sformatf("%s:x%0d_addr", name, j), 64'(log_q[log_base + j].addr), 64'(e.addr));
      if (e.wr)
        chk($sformatf("%s:x%0d_data", name, j), 64'(log_q[log_base + j].data), 64'(e.data));
      chk($sformatf("%s:x%0d_hold", name, j), 64'(log_q[log_base + j].hold_ok), 64'(1));
    end
    chk({name, ":done_once"}, 64'(done_total - done_base), 64'(1));
    chk({name, ":error_sticky"}, 64'(error), 64'(exp_err));
    chk({name, ":idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin : main
    int n, len, err;
    logic [31:0] s, d;

    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 3, 1, -1, 1'b0, 3, 1'b0, 6, "basic3"};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 0, 1, -1, 1'b0, 0, 1'b0, 0, "len0"};
    vecs[2] = '{32'h0000_0300, 32'h0000_0400, 4, 1, 3, 1'b0, 1, 1'b1, 4, "err_wr2"};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0500, 2, 1, 2, 1'b1, 1, 1'b1, 3, "wrap_both"};
    vecs[4] = '{32'h0000_0600, 32'h0000_0700, 5, 2, 0, 1'b0, 0, 1'b1, 1, "err_rd1"};
    vecs[5] = '{32'h0000_0800, 32'h0000_0900, 1, 3, -1, 1'b0, 1, 1'b0, 2, "slow1"};
    vecs[6] = '{32'h0000_1234, 32'hFFFF_FFF8, 3, 2, -1, 1'b0, 3, 1'b0, 6, "dst_wrap"};
    vecs[7] = '{32'h0000_0A00, 32'h0000_0B00, 2, 1, 3, 1'b0, 1, 1'b1, 4, "err_last"};
    vecs[8] = '{32'h0000_0003, 32'h0000_0007, 2, 1, -1, 1'b0, 2, 1'b0, 4, "unaligned"};

    wb_rst = 1'b1; cfg_start = 1'b0;
    cfg_src = 32'h0; cfg_dst = 32'h0; cfg_len = 16'h0;
    repeat (3) @(negedge wb_clk);
    chk("reset:busy", 64'(busy), 64'(0));
    chk("reset:done", 64'(done), 64'(0));
    chk("reset:error", 64'(error), 64'(0));
    chk("reset:words", 64'(words_done), 64'(0));
    chk("reset:start", 64'(start), 64'(0));
    chk("reset:address", 64'(address), 64'(0));
    chk("reset:write", 64'(write), 64'(0));
    chk("reset:data_wr", 64'(data_wr), 64'(0));
    chk("reset:selection", 64'(selection), 64'(4'hF));
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);

    for (int i = 0; i < 9; i++) begin
      lat_cfg = vecs[i].lat; err_cfg = vecs[i].err_idx; both_cfg = vecs[i].both;
      launch(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].name);
      finish_check(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].exp_words,
                   vecs[i].exp_err, vecs[i].exp_xfers, vecs[i].name);
    end

    // cfg_start mid-job with other values must not disturb the running job.
    lat_cfg = 1; err_cfg = -1; both_cfg = 1'b0;
    launch(32'h0000_0100, 32'h0000_0200, 3, "midjob");
    repeat (3) @(negedge wb_clk);
    cfg_src = 32'h0000_0900; cfg_dst = 32'h0000_0A00; cfg_len = 16'd7; cfg_start = 1'b1;
    @(negedge wb_clk);
    cfg_start = 1'b0;
    chk("midjob:still_busy", 64'(busy), 64'(1));
    finish_check(32'h0000_0100, 32'h0000_0200, 3, 3, 1'b0, 6, "midjob");

    // A new job is accepted in the cycle done is visible.
    launch(32'h0, 32'h0, 0, "b2b0");
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge wb_clk);
      n++;
    end
    chk("b2b0:done_seen", 64'(done), 64'(1));
    chk("b2b0:no_xfer", 64'(log_q.size() - log_base), 64'(0));
    launch(32'h0000_0040, 32'h0000_0080, 1, "b2b1");
    finish_check(32'h0000_0040, 32'h0000_0080, 1, 1, 1'b0, 2, "b2b1");

    // Asynchronous reset while waiting on the second read.
    lat_cfg = 4;
    launch(32'h0000_0100, 32'h0000_0200, 3, "rst");
    n = 0;
    while (log_q.size() - log_base < 3 && n < 200) begin
      @(negedge wb_clk);
      n++;
    end
    chk("rst:reach_rd2", 64'(log_q.size() - log_base), 64'(3));
    #2 wb_rst = 1'b1;
    #1;
    chk("rst:busy", 64'(busy), 64'(0));
    chk("rst:start", 64'(start), 64'(0));
    chk("rst:address", 64'(address), 64'(0));
    chk("rst:write", 64'(write), 64'(0));
    chk("rst:data_wr", 64'(data_wr), 64'(0));
    chk("rst:words", 64'(words_done), 64'(0));
    chk("rst:selection", 64'(selection), 64'(4'hF));
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (8) @(negedge wb_clk);
    chk("rst:no_done", 64'(done_total - done_base), 64'(0));
    chk("rst:no_more_xfer", 64'(log_q.size() - log_base), 64'(3));
    chk("rst:idle_busy", 64'(busy), 64'(0));
    lat_cfg = 1;
    launch(32'h0000_0100, 32'h0000_0200, 2, "after_rst");
    finish_check(32'h0000_0100, 32'h0000_0200, 2, 2, 1'b0, 4, "after_rst");

    // Randomized jobs against the transfer-list model.
    lat_cfg = 0;
    for (int r = 0; r < 30; r++) begin
      s   = $urandom;
      d   = $urandom;
      len = int'($urandom_range(0, 6));
      err = -1;
      if (len > 0 && $urandom_range(0, 3) == 0) err = int'($urandom_range(0, 2 * len - 1));
      err_cfg  = err;
      both_cfg = 1'($urandom_range(0, 1));
      launch(s, d, len, $sformatf("rnd%0d", r));
      finish_check(s, d, len, model_words(len, err), err >= 0, model_xfers(len, err),
                   $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
